// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch/prefetch unit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package fetch_pkg;

  localparam int unsigned DefaultMemWidth = `DATA_WIDTH;

  typedef enum logic [0:0] {
    StFetch,
    StFull
  } fetch_state_e;

  // Memory beats needed to assemble one instruction.
  function automatic int unsigned beats(input int unsigned inst_width,
                                        input int unsigned mem_width);
    return inst_width / mem_width;
  endfunction

  function automatic int unsigned bytes_per_beat(input int unsigned mem_width);
    return mem_width / 8;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO; entry 0 is always the head, vacated slots read as zero.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = logic [63:0],
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  entry_t          data_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o,
  output entry_t          head_o
);

  entry_t          entries_q [DEPTH];
  entry_t          entries_d [DEPTH];
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q;

  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_d[i] = '0;
      count_d = '0;
    end else begin
      // Pop first so a push into a full queue with a pop lands in the freed slot.
      if (pop_i && count_q != '0) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) entries_d[i] = entries_q[i + 1];
        entries_d[DEPTH-1] = '0;
        count_d = count_q - 1'b1;
      end
      if (push_i && count_d != CntW'(DEPTH)) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (count_d == CntW'(i)) entries_d[i] = data_i;
        end
        count_d = count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      full_q    <= (count_d == CntW'(DEPTH));
      empty_q   <= (count_d == '0);
    end
  end

  assign head_o  = entries_q[0];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: assembles narrow memory beats into instructions and
// buffers them for decode, with a single-cycle PC redirect.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned           INST_WIDTH = 32,
  parameter int unsigned           MEM_WIDTH  = DefaultMemWidth,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_pc_load,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_req,
  output logic                  o_mem_write,
  input  logic [MEM_WIDTH-1:0]  i_mem_data,
  input  logic                  i_mem_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_inst_pc,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int unsigned Beats = beats(INST_WIDTH, MEM_WIDTH);
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] BeatStep = ADDR_WIDTH'(bytes_per_beat(MEM_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] InstStep = ADDR_WIDTH'(INST_WIDTH / 8);

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BeatW-1:0]      beat_q;
  logic [INST_WIDTH-1:0] asm_q, asm_d;

  logic            accept, last_beat, push, pop, next_full;
  logic            q_full, q_empty;
  logic [CntW-1:0] q_count;
  entry_t          q_head, push_entry;

  assign o_mem_req   = (state_q == StFetch);
  assign o_mem_addr  = addr_q;
  assign o_mem_write = 1'b0;

  assign accept    = o_mem_req & i_mem_valid;
  assign last_beat = accept && (beat_q == BeatW'(Beats - 1));
  assign push      = last_beat && !i_pc_load;
  assign pop       = !q_empty && i_ready;

  // Queue occupancy after this cycle's push/pop reaches DEPTH.
  assign next_full = (q_full && !pop) ||
                     (push && !pop && q_count == CntW'(DEPTH - 1));

  // First beat lands in the MSBs.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < int'(Beats); k++) begin
      if (beat_q == BeatW'(k)) asm_d[INST_WIDTH-1-k*MEM_WIDTH -: MEM_WIDTH] = i_mem_data;
    end
  end

  assign push_entry = '{inst: asm_d, pc: base_q};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StFetch;
      addr_q  <= RESET_PC;
      base_q  <= RESET_PC;
      beat_q  <= '0;
      asm_q   <= '0;
    end else if (i_pc_load) begin
      state_q <= StFetch;
      addr_q  <= i_pc;
      base_q  <= i_pc;
      beat_q  <= '0;
      asm_q   <= '0;
    end else begin
      if (accept) begin
        if (last_beat) begin
          beat_q <= '0;
          asm_q  <= '0;
          base_q <= base_q + InstStep;
          addr_q <= base_q + InstStep;
        end else begin
          beat_q <= beat_q + 1'b1;
          asm_q  <= asm_d;
          addr_q <= addr_q + BeatStep;
        end
      end
      unique case (state_q)
        StFetch: if (next_full) state_q <= StFull;
        StFull:  if (pop) state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_queue (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(i_pc_load),
    .data_i (push_entry),
    .full_o (q_full),
    .empty_o(q_empty),
    .count_o(q_count),
    .head_o (q_head)
  );

  assign o_valid   = !q_empty;
  assign o_inst    = q_head.inst;
  assign o_inst_pc = q_head.pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed and randomized bench for fetch_prefetch against a byte-memory stream model.
module tb_fetch_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit memory DUT
  logic        rst, pc_load, mem_req, mem_write, mem_valid, valid, ready;
  logic [31:0] pc, mem_addr, inst, inst_pc;
  logic [7:0]  mem_data;

  // 16-bit memory DUT
  logic        rst_b, pc_load_b, mem_req_b, mem_write_b, mem_valid_b, valid_b, ready_b;
  logic [31:0] pc_b, mem_addr_b, inst_b, inst_pc_b;
  logic [15:0] mem_data_b;
  logic [7:0]  addr_b_lo, addr_b_hi;

  logic [7:0] mem8 [256];

  assign mem_data   = mem8[mem_addr[7:0]];
  assign addr_b_lo  = mem_addr_b[7:0];
  assign addr_b_hi  = mem_addr_b[7:0] + 8'd1;
  assign mem_data_b = {mem8[addr_b_lo], mem8[addr_b_hi]};

  fetch_prefetch #(.INST_WIDTH(32), .MEM_WIDTH(8), .ADDR_WIDTH(32), .DEPTH(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_pc_load(pc_load),
    .o_mem_addr(mem_addr), .o_mem_req(mem_req), .o_mem_write(mem_write),
    .i_mem_data(mem_data), .i_mem_valid(mem_valid),
    .o_inst(inst), .o_inst_pc(inst_pc), .o_valid(valid), .i_ready(ready)
  );

  fetch_prefetch #(.INST_WIDTH(32), .MEM_WIDTH(16), .ADDR_WIDTH(32), .DEPTH(2)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_pc(pc_b), .i_pc_load(pc_load_b),
    .o_mem_addr(mem_addr_b), .o_mem_req(mem_req_b), .o_mem_write(mem_write_b),
    .i_mem_data(mem_data_b), .i_mem_valid(mem_valid_b),
    .o_inst(inst_b), .o_inst_pc(inst_pc_b), .o_valid(valid_b), .i_ready(ready_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Big-endian 32-bit word from the byte memory, wrapping within its 256 bytes.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {mem8[b], mem8[b + 8'd1], mem8[b + 8'd2], mem8[b + 8'd3]};
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    pc_load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] model_pc;
  logic [63:0] held;
  logic        hold_pending;
  int          n_hs;

  initial begin
    logic [7:0] init_bytes [8];
    init_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem8[i] = init_bytes[i];

    rst = 1'b1; pc = '0; pc_load = 1'b0; mem_valid = 1'b1; ready = 1'b1;
    rst_b = 1'b1; pc_b = '0; pc_load_b = 1'b0; mem_valid_b = 1'b1; ready_b = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_write", 64'(mem_write), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_req", 64'(mem_req), 64'd1);

    // Streaming with decode always ready
    repeat (3) @(negedge clk);
    check("lat_valid_p3", 64'(valid), 64'd0);
    @(negedge clk);
    check("p4_inst", 64'(inst), 64'hAABBCCDD);
    check("p4_pc", 64'(inst_pc), 64'd0);
    repeat (4) @(negedge clk);
    check("p8_inst", 64'(inst), 64'h11223344);
    check("p8_pc", 64'(inst_pc), 64'd4);

    // Back-pressure fills the queue
    ready = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    check("full_req", 64'(mem_req), 64'd0);
    check("full_addr", 64'(mem_addr), 64'd8);
    check("full_head", 64'(inst), 64'hAABBCCDD);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("pop_head", 64'(inst), 64'h11223344);
    check("pop_pc", 64'(inst_pc), 64'd4);
    check("pop_req", 64'(mem_req), 64'd1);
    repeat (2) @(negedge clk);
    check("stall_head", 64'(inst), 64'h11223344);

    // Memory valid every other cycle
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      mem_valid = (i % 2 == 0);
      @(negedge clk);
      if (i == 7) check("alt_valid_p7", 64'(valid), 64'd0);
    end
    check("alt_valid_p8", 64'(valid), 64'd1);
    check("alt_inst", 64'(inst), 64'hAABBCCDD);
    mem_valid = 1'b1;
    ready = 1'b1;

    // Redirect at posedge 2
    do_reset();
    @(negedge clk);
    pc = 32'd4;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    check("redir_valid", 64'(valid), 64'd0);
    check("redir_addr", 64'(mem_addr), 64'd4);
    check("redir_req", 64'(mem_req), 64'd1);
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      check("redir_wait", 64'(valid), 64'd0);
    end
    @(negedge clk);
    check("redir_v", 64'(valid), 64'd1);
    check("redir_inst", 64'(inst), 64'h11223344);
    check("redir_pc", 64'(inst_pc), 64'd4);

    // Reset at posedge 2
    do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_valid", 64'(valid), 64'd0);
    check("mrst_addr", 64'(mem_addr), 64'd0);
    check("mrst_req", 64'(mem_req), 64'd1);
    repeat (4) @(negedge clk);
    check("mrst_inst", 64'(inst), 64'hAABBCCDD);
    check("mrst_pc", 64'(inst_pc), 64'd0);

    // 16-bit memory width
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    check("w16_rst_addr", 64'(mem_addr_b), 64'd0);
    check("w16_rst_req", 64'(mem_req_b), 64'd1);
    repeat (2) @(negedge clk);
    check("w16_inst", 64'(inst_b), 64'hAABBCCDD);
    check("w16_pc", 64'(inst_pc_b), 64'd0);
    check("w16_addr", 64'(mem_addr_b), 64'd4);

    // Random valid/ready/redirect against the sequential-stream model
    do_reset();
    model_pc = '0;
    hold_pending = 1'b0;
    n_hs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold_pending) begin
        check("hold_valid", 64'(valid), 64'd1);
        check("hold_head", {inst_pc, inst}, held);
      end
      if (!valid) check("empty_zero", {inst_pc, inst}, 64'd0);
      mem_valid = ($urandom_range(0, 3) != 0);
      ready     = ($urandom_range(0, 2) != 0);
      pc_load   = ($urandom_range(0, 40) == 0);
      pc        = 32'($urandom_range(0, 255));
      if (pc_load) begin
        model_pc = pc;
        hold_pending = 1'b0;
      end else begin
        if (valid && ready) begin
          check("stream_inst", 64'(inst), 64'(word_at(model_pc)));
          check("stream_pc", 64'(inst_pc), 64'(model_pc));
          model_pc = model_pc + 32'd4;
          n_hs++;
        end
        hold_pending = valid && !ready;
        held = {inst_pc, inst};
      end
      @(negedge clk);
    end
    pc_load = 1'b0;
    check("progress", 64'(n_hs > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
